// File: rtl/ctx_loader_pkg.sv
// ctx_loader shared definitions: FSM states, header encodings
// and header field positions.
package ctx_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PAYLOAD,
      ST_BCAST,
      ST_START_WAIT
   } state_t;

   localparam logic [1:0] TY_PE    = 2'b00;
   localparam logic [1:0] TY_IM    = 2'b01;
   localparam logic [1:0] TY_START = 2'b10;
   localparam logic [1:0] TY_RSVD  = 2'b11;

   localparam int TY_MSB    = 31;
   localparam int CNT_MSB   = 29;
   localparam int CNT_LSB   = 24;
   localparam int BC_BIT    = 23;
   localparam int PE_LSB    = 16;
   localparam int MAX_COUNT = 64;

endpackage

// File: rtl/ctx_loader.sv
// Host stream to per-PE context memory writer, with optional
// broadcast to every PE and a START command gated on array idle.
module ctx_loader
   import ctx_loader_pkg::*;
#(
   parameter int PE_NUM_BITS   = 4,
   parameter int CTX_ADDR_BITS = 5,
   parameter int CTX_PE_BITS   = 32,
   parameter int CTX_IM_BITS   = 32
) (
   input  logic                                 CLK,
   input  logic                                 RST,
   input  logic                                 s_valid,
   output logic                                 s_ready,
   input  logic [31:0]                          s_data,
   input  logic                                 s_last,
   input  logic                                 array_busy_in,
   output logic [PE_NUM_BITS+CTX_ADDR_BITS-1:0] CTX_PE_addra_out,
   output logic [CTX_PE_BITS-1:0]               CTX_PE_dina_out,
   output logic                                 CTX_PE_ena_out,
   output logic                                 CTX_PE_wea_out,
   output logic [PE_NUM_BITS+CTX_ADDR_BITS-1:0] CTX_IM_addra_out,
   output logic [CTX_IM_BITS-1:0]               CTX_IM_dina_out,
   output logic                                 CTX_IM_ena_out,
   output logic                                 CTX_IM_wea_out,
   output logic                                 start_out,
   output logic                                 busy_out,
   output logic                                 err_out
);

   localparam int AW = PE_NUM_BITS + CTX_ADDR_BITS;

   state_t                   state_q, state_d;
   logic [6:0]               rem_q, rem_d;
   logic [CTX_ADDR_BITS-1:0] addr_q, addr_d;
   logic [PE_NUM_BITS-1:0]   pe_q, pe_d;
   logic [PE_NUM_BITS-1:0]   bidx_q, bidx_d;
   logic                     im_q, im_d;
   logic                     bc_q, bc_d;
   logic                     bend_q, bend_d;
   logic [31:0]              bdat_q, bdat_d;
   logic                     err_q, err_d;
   logic                     start_q, start_d;
   logic                     s_ready_q, busy_q;
   logic                     pe_ena_q, im_ena_q;
   logic [AW-1:0]            pe_addr_q, im_addr_q;
   logic [CTX_PE_BITS-1:0]   pe_din_q;
   logic [CTX_IM_BITS-1:0]   im_din_q;
   logic                     wr_go, accept, last;
   logic [AW-1:0]            wr_addr;
   logic [31:0]              wr_data;
   logic [1:0]               hdr_ty;

   assign accept = s_valid & s_ready_q;
   assign hdr_ty = s_data[TY_MSB -: 2];
   assign last   = s_last | (rem_q == 7'd1);

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      addr_d  = addr_q;
      pe_d    = pe_q;
      im_d    = im_q;
      bc_d    = bc_q;
      bidx_d  = bidx_q;
      bdat_d  = bdat_q;
      bend_d  = bend_q;
      err_d   = err_q;
      start_d = 1'b0;
      wr_go   = 1'b0;
      wr_addr = {pe_q, addr_q};
      wr_data = s_data;
      unique case (state_q)
         ST_IDLE: if (accept) begin
            unique case (hdr_ty)
               TY_PE, TY_IM: begin
                  if (s_last) begin
                     err_d = 1'b1;
                  end else begin
                     state_d = ST_PAYLOAD;
                     rem_d   = {1'b0, s_data[CNT_MSB:CNT_LSB]} + 7'd1;
                     addr_d  = s_data[CTX_ADDR_BITS-1:0];
                     pe_d    = s_data[PE_LSB +: PE_NUM_BITS];
                     im_d    = (hdr_ty == TY_IM);
                     bc_d    = s_data[BC_BIT];
                  end
               end
               TY_START: begin
                  if (array_busy_in) state_d = ST_START_WAIT;
                  else               start_d = 1'b1;
               end
               default: err_d = 1'b1;
            endcase
         end
         ST_PAYLOAD: if (accept) begin
            wr_go = 1'b1;
            err_d = err_q | (s_last & (rem_q != 7'd1));
            if (bc_q) begin
               // PE 0 goes out now; BCAST covers PE 1..N-1
               wr_addr = {{PE_NUM_BITS{1'b0}}, addr_q};
               bidx_d  = PE_NUM_BITS'(1);
               bdat_d  = s_data;
               bend_d  = last;
               state_d = ST_BCAST;
            end else begin
               addr_d = addr_q + CTX_ADDR_BITS'(1);
               rem_d  = rem_q - 7'd1;
               if (last) state_d = ST_IDLE;
            end
         end
         ST_BCAST: begin
            wr_go   = 1'b1;
            wr_addr = {bidx_q, addr_q};
            wr_data = bdat_q;
            bidx_d  = bidx_q + PE_NUM_BITS'(1);
            if (&bidx_q) begin
               addr_d  = addr_q + CTX_ADDR_BITS'(1);
               rem_d   = rem_q - 7'd1;
               state_d = bend_q ? ST_IDLE : ST_PAYLOAD;
            end
         end
         ST_START_WAIT: if (!array_busy_in) begin
            start_d = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= ST_IDLE;
         rem_q     <= '0;
         addr_q    <= '0;
         pe_q      <= '0;
         im_q      <= 1'b0;
         bc_q      <= 1'b0;
         bidx_q    <= '0;
         bdat_q    <= '0;
         bend_q    <= 1'b0;
         err_q     <= 1'b0;
         start_q   <= 1'b0;
         s_ready_q <= 1'b0;
         busy_q    <= 1'b0;
         pe_ena_q  <= 1'b0;
         im_ena_q  <= 1'b0;
         pe_addr_q <= '0;
         im_addr_q <= '0;
         pe_din_q  <= '0;
         im_din_q  <= '0;
      end else begin
         state_q   <= state_d;
         rem_q     <= rem_d;
         addr_q    <= addr_d;
         pe_q      <= pe_d;
         im_q      <= im_d;
         bc_q      <= bc_d;
         bidx_q    <= bidx_d;
         bdat_q    <= bdat_d;
         bend_q    <= bend_d;
         err_q     <= err_d;
         start_q   <= start_d;
         s_ready_q <= (state_d == ST_IDLE) || (state_d == ST_PAYLOAD);
         busy_q    <= (state_d != ST_IDLE);
         pe_ena_q  <= wr_go & ~im_q;
         im_ena_q  <= wr_go & im_q;
         if (wr_go && !im_q) begin
            pe_addr_q <= wr_addr;
            pe_din_q  <= wr_data[CTX_PE_BITS-1:0];
         end
         if (wr_go && im_q) begin
            im_addr_q <= wr_addr;
            im_din_q  <= wr_data[CTX_IM_BITS-1:0];
         end
      end
   end

   assign s_ready          = s_ready_q;
   assign busy_out         = busy_q;
   assign err_out          = err_q;
   assign start_out        = start_q;
   assign CTX_PE_ena_out   = pe_ena_q;
   assign CTX_PE_wea_out   = pe_ena_q;
   assign CTX_PE_addra_out = pe_addr_q;
   assign CTX_PE_dina_out  = pe_din_q;
   assign CTX_IM_ena_out   = im_ena_q;
   assign CTX_IM_wea_out   = im_ena_q;
   assign CTX_IM_addra_out = im_addr_q;
   assign CTX_IM_dina_out  = im_din_q;

endmodule

// File: tb/tb_ctx_loader.sv
// Self-checking bench for ctx_loader: write streams, broadcast,
// wrap, START gating, error cases and mid-command reset.
module tb_ctx_loader;

   localparam int N = 16;

   typedef struct packed {
      logic        im;
      logic [8:0]  a;
      logic [31:0] d;
      logic [31:0] t;
   } wr_t;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [31:0] s_data = '0;
   logic        s_last = 1'b0;
   logic        array_busy_in = 1'b0;
   logic [8:0]  CTX_PE_addra_out, CTX_IM_addra_out;
   logic [31:0] CTX_PE_dina_out, CTX_IM_dina_out;
   logic        CTX_PE_ena_out, CTX_PE_wea_out;
   logic        CTX_IM_ena_out, CTX_IM_wea_out;
   logic        start_out, busy_out, err_out;

   logic [31:0] cyc = '0;
   int          total = 0;
   int          bad = 0;
   int          wea_bad = 0;
   int          clash = 0;
   wr_t         log_q[$];
   wr_t         exp_q[$];
   logic [31:0] dq[$];
   int          st_q[$];
   int          start_q[$];

   ctx_loader dut (
      .CLK(CLK), .RST(RST),
      .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .s_last(s_last),
      .array_busy_in(array_busy_in),
      .CTX_PE_addra_out(CTX_PE_addra_out),
      .CTX_PE_dina_out(CTX_PE_dina_out),
      .CTX_PE_ena_out(CTX_PE_ena_out),
      .CTX_PE_wea_out(CTX_PE_wea_out),
      .CTX_IM_addra_out(CTX_IM_addra_out),
      .CTX_IM_dina_out(CTX_IM_dina_out),
      .CTX_IM_ena_out(CTX_IM_ena_out),
      .CTX_IM_wea_out(CTX_IM_wea_out),
      .start_out(start_out),
      .busy_out(busy_out),
      .err_out(err_out)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (CTX_PE_ena_out)
         log_q.push_back({1'b0, CTX_PE_addra_out, CTX_PE_dina_out, cyc});
      if (CTX_IM_ena_out)
         log_q.push_back({1'b1, CTX_IM_addra_out, CTX_IM_dina_out, cyc});
      if (start_out) start_q.push_back(int'(cyc));
      if (CTX_PE_wea_out !== CTX_PE_ena_out || CTX_IM_wea_out !== CTX_IM_ena_out)
         wea_bad <= wea_bad + 1;
      if (start_out && (CTX_PE_ena_out || CTX_IM_ena_out))
         clash <= clash + 1;
   end

   function automatic logic [31:0] hdr(input logic [1:0] ty, input int cnt,
                                       input logic bc, input logic [3:0] pe,
                                       input logic [4:0] base);
      logic [5:0] c;
      c = 6'(cnt - 1);
      return {ty, c, bc, 3'b000, pe, 11'd0, base};
   endfunction

   // called at a negedge; returns at the negedge after the accepting edge
   task automatic send(input logic [31:0] d, input logic l, output int st);
      int n;
      n = 0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      while (!s_ready && n < 200) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 200) begin
         total++;
         bad++;
         $display("FAIL send_timeout got=ready_low exp=accept data=%h", d);
      end
      @(posedge CLK);
      @(negedge CLK);
      st = int'(cyc);
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
   endtask

   // reference: word j of a command lands at (base+j) mod 32; broadcast
   // puts it on every PE p at its accept stamp + p
   task automatic run_cmd(input logic [1:0] ty, input logic [3:0] pe,
                          input int base, input logic bc,
                          input int cnt, input int last_at);
      int st, nw;
      logic [4:0] a;
      log_q.delete();
      exp_q.delete();
      st_q.delete();
      send(hdr(ty, cnt, bc, pe, 5'(base)), 1'b0, st);
      st_q.push_back(st);
      nw = (last_at > 0) ? last_at : cnt;
      for (int j = 0; j < nw; j++) begin
         send(dq[j], (last_at > 0) && (j == nw - 1), st);
         st_q.push_back(st);
         a = 5'((base + j) % 32);
         if (bc) begin
            for (int p = 0; p < N; p++)
               exp_q.push_back({ty[0], 4'(p), a, dq[j], 32'(st + p)});
         end else begin
            exp_q.push_back({ty[0], pe, a, dq[j], 32'(st)});
         end
      end
      repeat (N + 4) @(negedge CLK);
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (3) @(negedge CLK);
      total++;
      if ({s_ready, CTX_PE_ena_out, CTX_IM_ena_out, start_out, busy_out, err_out} !== 6'd0
          || CTX_PE_addra_out !== 9'd0 || CTX_IM_dina_out !== 32'd0) begin
         bad++;
         $display("FAIL reset_vals got=%b exp=0", {s_ready, CTX_PE_ena_out,
                  CTX_IM_ena_out, start_out, busy_out, err_out});
      end
      RST = 1'b0;
      #1;
      total++;
      if (s_ready !== 1'b0) begin
         bad++;
         $display("FAIL ready_at_release got=%b exp=0", s_ready);
      end
      @(negedge CLK);
      total++;
      if (s_ready !== 1'b1) begin
         bad++;
         $display("FAIL ready_after_release got=%b exp=1", s_ready);
      end
   endtask

   task automatic test_pe_ctx();
      dq = {32'hA0, 32'hA1, 32'hA2, 32'hA3};
      run_cmd(2'b00, 4'd3, 0, 1'b0, 4, 0);
      total++;
      if (log_q.size() != exp_q.size()) begin
         bad++;
         $display("FAIL pe_ctx_count got=%0d exp=%0d", log_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
         total++;
         if (log_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL pe_ctx_wr%0d got=%h exp=%h", i, log_q[i], exp_q[i]);
         end
      end
      for (int j = 1; j < st_q.size(); j++) begin
         total++;
         if (st_q[j] != st_q[0] + j) begin
            bad++;
            $display("FAIL pe_ctx_thru%0d got=%0d exp=%0d", j, st_q[j], st_q[0] + j);
         end
      end
   endtask

   task automatic test_bcast();
      dq = {32'h11, 32'h22};
      run_cmd(2'b01, 4'd0, 7, 1'b1, 2, 0);
      total++;
      if (log_q.size() != 2 * N) begin
         bad++;
         $display("FAIL bcast_count got=%0d exp=%0d", log_q.size(), 2 * N);
      end
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
         total++;
         if (log_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL bcast_wr%0d got=%h exp=%h", i, log_q[i], exp_q[i]);
         end
      end
      total++;
      if (st_q[2] - st_q[1] != N) begin
         bad++;
         $display("FAIL bcast_spacing got=%0d exp=%0d", st_q[2] - st_q[1], N);
      end
   endtask

   task automatic test_wrap();
      dq = {32'h5A5A0001, 32'h5A5A0002, 32'h5A5A0003, 32'h5A5A0004};
      run_cmd(2'b00, 4'd1, 30, 1'b0, 4, 0);
      total++;
      if (log_q.size() != exp_q.size()) begin
         bad++;
         $display("FAIL wrap_count got=%0d exp=%0d", log_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
         total++;
         if (log_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL wrap_wr%0d got=%h exp=%h", i, log_q[i], exp_q[i]);
         end
      end
      total++;
      if (err_out !== 1'b0) begin
         bad++;
         $display("FAIL wrap_err got=%b exp=0", err_out);
      end
   endtask

   task automatic test_random();
      logic [1:0] ty;
      logic [3:0] pe;
      logic       bc;
      int         base, cnt;
      for (int k = 0; k < 6; k++) begin
         ty   = 2'($urandom_range(0, 1));
         pe   = 4'($urandom_range(0, 15));
         base = int'($urandom_range(0, 31));
         bc   = ($urandom_range(0, 2) == 0);
         cnt  = bc ? int'($urandom_range(1, 3)) : int'($urandom_range(1, 10));
         dq.delete();
         for (int j = 0; j < cnt; j++) dq.push_back($urandom);
         run_cmd(ty, pe, base, bc, cnt, 0);
         total++;
         if (log_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL rand%0d_count got=%0d exp=%0d", k, log_q.size(), exp_q.size());
         end
         for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            total++;
            if (log_q[i] !== exp_q[i]) begin
               bad++;
               $display("FAIL rand%0d_wr%0d got=%h exp=%h", k, i, log_q[i], exp_q[i]);
            end
         end
      end
      total++;
      if (err_out !== 1'b0) begin
         bad++;
         $display("FAIL rand_err got=%b exp=0", err_out);
      end
   endtask

   task automatic test_start();
      int st, b;
      start_q.delete();
      array_busy_in = 1'b1;
      send(hdr(2'b10, 1, 1'b0, 4'd0, 5'd0), 1'b0, st);
      repeat (10) @(negedge CLK);
      total++;
      if (start_q.size() != 0 || busy_out !== 1'b1) begin
         bad++;
         $display("FAIL start_early got=%0d/%b exp=0/1", start_q.size(), busy_out);
      end
      array_busy_in = 1'b0;
      b = int'(cyc);
      repeat (4) @(negedge CLK);
      total++;
      if (start_q.size() != 1 || start_q[0] != b + 1) begin
         bad++;
         $display("FAIL start_pulse got=%0d pulses exp=1 at %0d", start_q.size(), b + 1);
      end
      total++;
      if (busy_out !== 1'b0) begin
         bad++;
         $display("FAIL start_busy got=%b exp=0", busy_out);
      end
      start_q.delete();
      send(hdr(2'b10, 1, 1'b0, 4'd0, 5'd0), 1'b0, st);
      repeat (3) @(negedge CLK);
      total++;
      if (start_q.size() != 1 || start_q[0] != st) begin
         bad++;
         $display("FAIL start_idle got=%0d pulses exp=1 at %0d", start_q.size(), st);
      end
   endtask

   task automatic test_premature();
      dq = {32'hC1, 32'hC2, 32'hC3, 32'hC4, 32'hC5};
      run_cmd(2'b00, 4'd6, 10, 1'b0, 5, 2);
      total++;
      if (log_q.size() != 2 || exp_q.size() != 2) begin
         bad++;
         $display("FAIL early_last_count got=%0d exp=2", log_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
         total++;
         if (log_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL early_last_wr%0d got=%h exp=%h", i, log_q[i], exp_q[i]);
         end
      end
      total++;
      if (err_out !== 1'b1) begin
         bad++;
         $display("FAIL early_last_err got=%b exp=1", err_out);
      end
      dq = {32'hBEEF0001};
      run_cmd(2'b01, 4'd2, 3, 1'b0, 1, 0);
      total++;
      if (log_q.size() != 1 || log_q[0] !== exp_q[0]) begin
         bad++;
         $display("FAIL early_last_next got=%0d writes exp=1 %h", log_q.size(), exp_q[0]);
      end
   endtask

   task automatic test_reset_mid();
      int st, n;
      log_q.delete();
      send(hdr(2'b00, 1, 1'b1, 4'd0, 5'd2), 1'b0, st);
      send(32'hDEADBEEF, 1'b0, st);
      n = 0;
      while (!(CTX_PE_ena_out && CTX_PE_addra_out[8:5] == 4'd5) && n < 40) begin
         @(negedge CLK);
         n++;
      end
      total++;
      if (n >= 40) begin
         bad++;
         $display("FAIL mid_reset_pe5 got=timeout exp=strobe");
      end
      #1 RST = 1'b1;
      #1;
      total++;
      if ({s_ready, CTX_PE_ena_out, CTX_IM_ena_out, start_out, busy_out, err_out} !== 6'd0
          || CTX_PE_addra_out !== 9'd0 || CTX_PE_dina_out !== 32'd0) begin
         bad++;
         $display("FAIL mid_reset_vals got=%b exp=0", {s_ready, CTX_PE_ena_out,
                  CTX_IM_ena_out, start_out, busy_out, err_out});
      end
      log_q.delete();
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      repeat (N + 2) @(negedge CLK);
      total++;
      if (log_q.size() != 0) begin
         bad++;
         $display("FAIL mid_reset_strobes got=%0d exp=0", log_q.size());
      end
      dq = {32'h77, 32'h78, 32'h79};
      run_cmd(2'b00, 4'd9, 4, 1'b0, 3, 0);
      total++;
      if (log_q.size() != 3) begin
         bad++;
         $display("FAIL mid_reset_next got=%0d exp=3", log_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
         total++;
         if (log_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL mid_reset_wr%0d got=%h exp=%h", i, log_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_errors();
      int st;
      do_reset();
      send(32'hC000_0000, 1'b0, st);
      @(negedge CLK);
      total++;
      if (err_out !== 1'b1 || s_ready !== 1'b1) begin
         bad++;
         $display("FAIL rsvd_err got=%b/%b exp=1/1", err_out, s_ready);
      end
      do_reset();
      log_q.delete();
      send(hdr(2'b01, 3, 1'b0, 4'd2, 5'd0), 1'b1, st);
      repeat (4) @(negedge CLK);
      total++;
      if (err_out !== 1'b1 || log_q.size() != 0 || s_ready !== 1'b1) begin
         bad++;
         $display("FAIL hdr_last got=%b/%0d/%b exp=1/0/1", err_out, log_q.size(), s_ready);
      end
      dq = {32'h1234};
      run_cmd(2'b00, 4'd15, 31, 1'b0, 1, 0);
      total++;
      if (log_q.size() != 1 || log_q[0] !== exp_q[0]) begin
         bad++;
         $display("FAIL err_next got=%0d writes exp=1 %h", log_q.size(), exp_q[0]);
      end
   endtask

   task automatic test_invariants();
      total++;
      if (wea_bad != 0) begin
         bad++;
         $display("FAIL wea_eq_ena got=%0d exp=0", wea_bad);
      end
      total++;
      if (clash != 0) begin
         bad++;
         $display("FAIL start_vs_write got=%0d exp=0", clash);
      end
   endtask

   initial begin
      @(negedge CLK);
      test_reset();
      test_pe_ctx();
      test_bcast();
      test_wrap();
      test_random();
      test_start();
      test_premature();
      test_reset_mid();
      test_errors();
      test_invariants();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1);
   end

endmodule
